// File: rtl/delay_ctrl_rpt.sv
// delay_ctrl_rpt
//   Push-button delay selector with auto-repeat. Two raw active-high keys are
//   synchronised, edge-detected and turned into single steps of a saturating
//   WIDTH-bit delay value. A held key steps again after HOLD_CYCLES and then
//   every REPEAT_CYCLES.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   ctrl_key  in   [1] = faster (decrement), [0] = slower (increment)
//   delay     out  current delay value (registered)
//   changed   out  one-cycle pulse in the cycle after delay changed (registered)
//   at_min    out  delay == MIN
//   at_max    out  delay == MAX
module delay_ctrl_rpt #(
    parameter int WIDTH         = 3,
    parameter int MIN           = 1,
    parameter int MAX           = 7,
    parameter int INIT          = 1,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ctrl_key,
    output logic [WIDTH-1:0] delay,
    output logic             changed,
    output logic             at_min,
    output logic             at_max
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [WIDTH-1:0] MIN_V       = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V       = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V      = WIDTH'(INIT);

    // dir encoding doubles as the key index: 1 = faster key, 0 = slower key
    localparam logic DIR_FAST = 1'b1;
    localparam logic DIR_SLOW = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] delay_q, delay_d;
    logic             changed_q, changed_d;
    logic [1:0]       s1_q, s2_q, prev_q;
    logic [1:0]       press;
    logic             do_step;
    logic             step_fast;

    // Saturating single step; returns the input unchanged at the limit.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                    input logic             fast);
        if (fast) begin
            step_value = (cur == MIN_V) ? cur : cur - WIDTH'(1);
        end else begin
            step_value = (cur == MAX_V) ? cur : cur + WIDTH'(1);
        end
    endfunction

    assign press = s2_q & ~prev_q;

    // State register, synchroniser and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 2'b00;
            s2_q      <= 2'b00;
            prev_q    <= 2'b00;
            state_q   <= IDLE;
            dir_q     <= DIR_SLOW;
            cnt_q     <= '0;
            delay_q   <= INIT_V;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= ctrl_key;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            delay_q   <= delay_d;
            changed_q <= changed_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        do_step   = 1'b0;
        step_fast = dir_q;
        case (state_q)
            IDLE: begin
                // faster wins a simultaneous press
                if (press[1]) begin
                    do_step   = 1'b1;
                    step_fast = DIR_FAST;
                    dir_d     = DIR_FAST;
                    cnt_d     = '0;
                    state_d   = HOLD;
                end else if (press[0]) begin
                    do_step   = 1'b1;
                    step_fast = DIR_SLOW;
                    dir_d     = DIR_SLOW;
                    cnt_d     = '0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (!s2_q[dir_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!s2_q[dir_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        delay_d   = do_step ? step_value(delay_q, step_fast) : delay_q;
        // a step suppressed at a limit leaves changed low
        changed_d = (delay_d != delay_q);
    end

    // Outputs
    always_comb begin
        delay   = delay_q;
        changed = changed_q;
        at_min  = (delay_q == MIN_V);
        at_max  = (delay_q == MAX_V);
    end

endmodule
